fop_seq_checker: RTL and testbench
==================================

// Module: fop_seq_checker
// PURPOSE
//  Sequential, width-parametrised "Fibonacci-or-prime" classifier. Accepts one unsigned W-bit operand over a
//  valid/ready handshake and returns out_fop=1 iff the operand is a Fibonacci number (0,1,2,3,5,8,13,...) or a prime.
//  For W=4 the result matches the combinational fop_* set {0,1,2,3,5,7,8,11,13}.
//  Sits between a stimulus/producer stage and a result consumer; one operand in flight at a time.
// PARAMETERS
//  W        8   operand width in bits, 2..16
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operand offered
//  in_ready   out  1  block can accept an operand (high only in IDLE)
//  in_data    in   W  unsigned operand
//  out_valid  out  1  result held for the consumer
//  out_ready  in   1  consumer accepts the result
//  out_fop    out  1  1 = Fibonacci or prime
//  out_fib    out  1  (FOP_SPLIT_EN only) operand is Fibonacci
//  out_prime  out  1  (FOP_SPLIT_EN only) operand is prime
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_fop/out_fib/out_prime=0, datapath regs 0.
//  - States: IDLE -> FIB -> PRIME -> DONE -> IDLE.
//  - IDLE: in_valid&in_ready captures in_data to x; a=0, b=1 (W+2 bits); next state FIB.
//  - FIB, one step per cycle: a==x -> fib=1; a>x -> fib=0; else (a,b)<=(b,a+b). W+2 bits is overflow-free.
//    fib=1: go DONE with fop=1 (short-circuit, PRIME skipped). fib=0: go PRIME with d=2.
//  - PRIME, one divisor per cycle: x<2 -> prime=0; d*d>x (2W-bit product) -> prime=1; x%d==0 -> prime=0;
//    else d<=d+1. Divisor compare/remainder is combinational; no multicycle paths.
//  - DONE: out_valid=1, outputs stable until out_valid&out_ready; then IDLE next cycle.
//    in_ready=0 in FIB/PRIME/DONE; no operand is accepted the same cycle a result retires.
//  - Latency (capture to out_valid): 1 + fib steps [+ prime steps] + 1. Worst case for W=16 is below 300 cycles.
//  - out_valid never drops without out_ready; in_data is ignored outside IDLE.
//  - Reset mid-operation aborts the operand immediately; no result is emitted.
//  - Boundary operands: x=0 -> 1 (fib); x=1 -> 1 (fib); x=2^W-1 handled without wrap; x=4 -> 0.
// CONFIGURATION
//  FOP_SPLIT_EN defined:
//    - FIB never short-circuits; PRIME always runs.
//    - out_fib and out_prime report both verdicts; out_fop = out_fib | out_prime.
//  FOP_SPLIT_EN undefined:
//    - out_fib and out_prime do not exist; short-circuit applies.
//    - Latency for Fibonacci operands is lower.
// STRUCTURE
//  - Shared package fop_pkg:
//    - state enum/localparams S_IDLE, S_FIB, S_PRIME, S_DONE;
//    - FOP_W_MAX=16;
//    - reference function fop_ref(x) used by benches.
//  - One sub-module, fop_prime_step: combinational per-cycle divisor test.
//    - In: x, d. Out: done, is_prime.
//    - Reused by future pipelined variants.
//  - FSM and Fibonacci datapath stay in the top level.
// TESTING
//  1. W=4, in_data 0..15 sequentially, out_ready=1 -> out_fop=1 exactly for {0,1,2,3,5,7,8,11,13}.
//  2. W=8: 89->1 (fib); 97->1 (prime); 91->0 (7*13); 255->0; 233->1.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_fop stable, in_ready=0; result retires on the first out_ready.
//  4. Assert rst mid-PRIME on 251 -> outputs zero immediately, in_ready=1 after release, no stray out_valid.
//     A following operand 4 -> 0.
//  5. FOP_SPLIT_EN, W=8: 233 -> fib=1 prime=1; 13 -> 1/1; 21 -> 1/0; 7 -> 0/1; 9 -> 0/0.
//  6. W=16 random 2000 operands vs fop_ref, random out_ready -> zero mismatches.
//     Latency never exceeds the computed bound.

Source files
------------

// File: rtl/fop_pkg.sv
// Shared types and constants for the Fibonacci-or-prime classifier family.
// fop_ref() is a loop-based golden classifier for operands up to FOP_W_MAX bits.
package fop_pkg;

   localparam int FOP_W_MAX = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIB   = 2'd1,
      S_PRIME = 2'd2,
      S_DONE  = 2'd3
   } fop_state_t;

   // 26 Fibonacci steps reach past 2^16; divisors up to 255 cover every 16-bit composite.
   function automatic logic fop_ref(input logic [FOP_W_MAX-1:0] x);
      logic [FOP_W_MAX+1:0] a;
      logic [FOP_W_MAX+1:0] b;
      logic [FOP_W_MAX+1:0] t;
      logic                 is_fib;
      logic                 is_prime;
      a      = '0;
      b      = (FOP_W_MAX+2)'(1);
      is_fib = 1'b0;
      for (int i = 0; i < 26; i++) begin
         if (a == {2'b00, x}) is_fib = 1'b1;
         t = a + b;
         a = b;
         b = t;
      end
      is_prime = (x >= FOP_W_MAX'(2));
      for (int d = 2; d < 256; d++) begin
         if (((d * d) <= int'(x)) && ((int'(x) % d) == 0)) is_prime = 1'b0;
      end
      return is_fib | is_prime;
   endfunction

endpackage

// File: rtl/fop_prime_step.sv
// One trial-division step: decides whether divisor d settles the primality of x.
// Purely combinational so it can be dropped into pipelined variants unchanged.
module fop_prime_step
   import fop_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_d,
   output logic         o_done,
   output logic         o_is_prime
);

   logic [2*W-1:0] w_d_ext;
   logic [2*W-1:0] w_x_ext;
   logic [2*W-1:0] w_sq;
   logic [W-1:0]   w_rem;

   assign w_d_ext = {{W{1'b0}}, i_d};
   assign w_x_ext = {{W{1'b0}}, i_x};
   assign w_sq    = w_d_ext * w_d_ext;
   assign w_rem   = (i_d == '0) ? '0 : (i_x % i_d);

   always_comb begin
      o_done     = 1'b0;
      o_is_prime = 1'b0;
      if (i_x < W'(2)) begin
         o_done = 1'b1;
      end else if (w_sq > w_x_ext) begin
         o_done     = 1'b1;
         o_is_prime = 1'b1;
      end else if (w_rem == '0) begin
         o_done = 1'b1;
      end
   end

endmodule

// File: rtl/fop_seq_checker.sv
// Sequential Fibonacci-or-prime classifier behind valid/ready handshakes, one operand in flight.
// Define FOP_SPLIT_EN to always run both tests and expose o_out_fib / o_out_prime.
module fop_seq_checker
   import fop_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
`ifdef FOP_SPLIT_EN
   output logic         o_out_fib,
   output logic         o_out_prime,
`endif
   output logic         o_out_fop
);

   // state   | meaning
   // S_IDLE  | waiting for an operand
   // S_FIB   | walking the Fibonacci sequence up to x
   // S_PRIME | trial division, one divisor per cycle
   // S_DONE  | result held until the consumer takes it

   fop_state_t   r_state;
   fop_state_t   w_state_nxt;
   logic [W-1:0] r_x;
   logic [W-1:0] r_d;
   logic [W+1:0] r_a;
   logic [W+1:0] r_b;
   logic         w_fib_hit;
   logic         w_fib_miss;
   logic         w_p_done;
   logic         w_p_prime;
   logic         w_in_done;
`ifdef FOP_SPLIT_EN
   logic         r_fib;
   logic         r_prime;
`else
   logic         r_fop;
`endif

   assign w_fib_hit  = (r_a == {2'b00, r_x});
   assign w_fib_miss = (r_a >  {2'b00, r_x});
   assign w_in_done  = (r_state == S_DONE);

   fop_prime_step #(.W(W)) u_prime_step (
      .i_x        (r_x),
      .i_d        (r_d),
      .o_done     (w_p_done),
      .o_is_prime (w_p_prime)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_in_valid) w_state_nxt = S_FIB;
`ifdef FOP_SPLIT_EN
         S_FIB:   if (w_fib_hit || w_fib_miss) w_state_nxt = S_PRIME;
`else
         S_FIB: begin
            if (w_fib_hit)       w_state_nxt = S_DONE;
            else if (w_fib_miss) w_state_nxt = S_PRIME;
         end
`endif
         S_PRIME: if (w_p_done)    w_state_nxt = S_DONE;
         S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x <= '0;
         r_d <= '0;
         r_a <= '0;
         r_b <= '0;
`ifdef FOP_SPLIT_EN
         r_fib   <= 1'b0;
         r_prime <= 1'b0;
`else
         r_fop <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_x <= i_in_data;
                  r_a <= '0;
                  r_b <= (W+2)'(1);
`ifdef FOP_SPLIT_EN
                  r_fib   <= 1'b0;
                  r_prime <= 1'b0;
`else
                  r_fop <= 1'b0;
`endif
               end
            end
            S_FIB: begin
               if (w_fib_hit) begin
`ifdef FOP_SPLIT_EN
                  r_fib <= 1'b1;
                  r_d   <= W'(2);
`else
                  r_fop <= 1'b1;
`endif
               end else if (w_fib_miss) begin
                  r_d <= W'(2);
               end else begin
                  // W+2 bits hold the first Fibonacci number above any W-bit x and its successor
                  r_a <= r_b;
                  r_b <= r_a + r_b;
               end
            end
            S_PRIME: begin
               if (w_p_done) begin
`ifdef FOP_SPLIT_EN
                  r_prime <= w_p_prime;
`else
                  r_fop <= w_p_prime;
`endif
               end else begin
                  r_d <= r_d + W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = w_in_done;
`ifdef FOP_SPLIT_EN
   assign o_out_fib   = w_in_done & r_fib;
   assign o_out_prime = w_in_done & r_prime;
   assign o_out_fop   = w_in_done & (r_fib | r_prime);
`else
   assign o_out_fop   = w_in_done & r_fop;
`endif

endmodule

// File: tb/tb_fop_seq_checker.sv
// Bench for fop_seq_checker: W=4, W=8 and W=16 instances checked against a behavioural model.
// Honours FOP_SPLIT_EN when defined.
module tb_fop_seq_checker;

   localparam int LAT_LIMIT = 300;

   logic        clk;
   logic        rst;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [3:0]  d4;
   logic [7:0]  d8;
   logic [15:0] d16;
   wire  [2:0]  ov;
   wire  [2:0]  ir;
   wire  [2:0]  fop;
`ifdef FOP_SPLIT_EN
   wire  [2:0]  ofib;
   wire  [2:0]  oprm;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   bit pend    [3];
   bit seen    [3];
   bit hold    [3];
   bit exp_fop [3];
   bit exp_fib [3];
   bit exp_prm [3];
   int exp_lat [3];
   int cap_cyc [3];
   int rmode   [3];

   fop_seq_checker #(.W(4)) u_w4 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(iv[0]), .o_in_ready(ir[0]), .i_in_data(d4),
      .o_out_valid(ov[0]), .i_out_ready(ordy[0]),
`ifdef FOP_SPLIT_EN
      .o_out_fib(ofib[0]), .o_out_prime(oprm[0]),
`endif
      .o_out_fop(fop[0]));

   fop_seq_checker #(.W(8)) u_w8 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(iv[1]), .o_in_ready(ir[1]), .i_in_data(d8),
      .o_out_valid(ov[1]), .i_out_ready(ordy[1]),
`ifdef FOP_SPLIT_EN
      .o_out_fib(ofib[1]), .o_out_prime(oprm[1]),
`endif
      .o_out_fop(fop[1]));

   fop_seq_checker #(.W(16)) u_w16 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(iv[2]), .o_in_ready(ir[2]), .i_in_data(d16),
      .o_out_valid(ov[2]), .i_out_ready(ordy[2]),
`ifdef FOP_SPLIT_EN
      .o_out_fib(ofib[2]), .o_out_prime(oprm[2]),
`endif
      .o_out_fop(fop[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- behavioural model ----------------
   function automatic bit m_is_fib(input int x);
      int a = 0, b = 1, t;
      while (a < x) begin t = a + b; a = b; b = t; end
      return a == x;
   endfunction

   function automatic int m_fib_steps(input int x);
      int a = 0, b = 1, t, n = 1;
      while (a < x) begin t = a + b; a = b; b = t; n++; end
      return n;
   endfunction

   function automatic bit m_is_prime(input int x);
      if (x < 2) return 1'b0;
      for (int d = 2; d * d <= x; d++) if (x % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int m_prime_steps(input int x);
      int d = 2;
      if (x < 2) return 1;
      while ((d * d <= x) && (x % d != 0)) d++;
      return d - 1;
   endfunction

   function automatic int m_latency(input int x);
`ifdef FOP_SPLIT_EN
      return m_fib_steps(x) + m_prime_steps(x);
`else
      return m_fib_steps(x) + (m_is_fib(x) ? 0 : m_prime_steps(x));
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   task automatic compare_inst(input int k);
      if (ov[k]) begin
         if (!pend[k]) begin
            check($sformatf("stray_valid[%0d]", k), ov[k], 1'b0);
         end else begin
            if (!seen[k]) begin
               seen[k] = 1'b1;
               check($sformatf("latency[%0d]", k), cyc - cap_cyc[k], exp_lat[k]);
            end
            check($sformatf("fop[%0d]", k), fop[k], exp_fop[k]);
            check($sformatf("in_ready_busy[%0d]", k), ir[k], 1'b0);
`ifdef FOP_SPLIT_EN
            check($sformatf("fib[%0d]", k), ofib[k], exp_fib[k]);
            check($sformatf("prime[%0d]", k), oprm[k], exp_prm[k]);
`endif
            if (ordy[k]) begin pend[k] = 1'b0; seen[k] = 1'b0; end
         end
      end else begin
         if (hold[k]) check($sformatf("valid_drop[%0d]", k), ov[k], 1'b1);
         if (pend[k] && (cyc - cap_cyc[k]) > LAT_LIMIT) begin
            check($sformatf("timeout[%0d]", k), cyc - cap_cyc[k], exp_lat[k]);
            pend[k] = 1'b0;
         end
      end
      hold[k] = ov[k] && !ordy[k];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) for (int k = 0; k < 3; k++) compare_inst(k);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            case (rmode[k])
               1:       ordy[k] = 1'($urandom_range(0, 1));
               2:       ordy[k] = 1'b0;
               default: ordy[k] = 1'b1;
            endcase
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input int k, input int x);
      logic [15:0] xv;
      int n = 0;
      xv = 16'(x);
      @(negedge clk);
      while (ir[k] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) check($sformatf("ready_wait[%0d]", k), ir[k], 1'b1);
      if (k == 0) d4 = xv[3:0];
      else if (k == 1) d8 = xv[7:0];
      else d16 = xv;
      exp_fib[k] = m_is_fib(x);
      exp_prm[k] = m_is_prime(x);
      exp_fop[k] = exp_fib[k] | exp_prm[k];
      exp_lat[k] = m_latency(x);
      cap_cyc[k] = cyc + 1;
      seen[k]    = 1'b0;
      pend[k]    = 1'b1;
      iv[k]      = 1'b1;
      @(posedge clk);
      #1 iv[k] = 1'b0;
   endtask

   task automatic wait_result(input int k, output bit g_fop, output bit g_fib,
                              output bit g_prm, output int lat);
      int n = 0;
      g_fib = 1'b0;
      g_prm = 1'b0;
      @(negedge clk);
      while (ov[k] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) check($sformatf("result_wait[%0d]", k), ov[k], 1'b1);
      g_fop = fop[k];
`ifdef FOP_SPLIT_EN
      g_fib = ofib[k];
      g_prm = oprm[k];
`endif
      lat = cyc - cap_cyc[k];
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] mask4;
      bit gf, gb, gp;
      int lat, n;
      int dir8 [5];
      bit exp8 [5];

      rst = 1'b1;
      iv = '0; ordy = '1; d4 = '0; d8 = '0; d16 = '0;
      for (int k = 0; k < 3; k++) begin
         pend[k] = 0; seen[k] = 0; hold[k] = 0; rmode[k] = 0; cap_cyc[k] = 0; exp_lat[k] = 0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_out_valid[%0d]", k), ov[k], 1'b0);
         check($sformatf("rst_in_ready[%0d]", k), ir[k], 1'b1);
         check($sformatf("rst_out_fop[%0d]", k), fop[k], 1'b0);
      end
      rst = 1'b0;

      // W=4 exhaustive sweep against the hand-written set {0,1,2,3,5,7,8,11,13}
      mask4 = 16'h29AF;
      for (int x = 0; x < 16; x++) begin
         send(0, x);
         wait_result(0, gf, gb, gp, lat);
         check($sformatf("w4_sweep_%0d", x), gf, mask4[x]);
      end

      // W=8 directed operands
      dir8 = '{89, 97, 91, 255, 233};
      exp8 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         send(1, dir8[i]);
         wait_result(1, gf, gb, gp, lat);
         check($sformatf("w8_dir_%0d", dir8[i]), gf, exp8[i]);
`ifdef FOP_SPLIT_EN
         if (i == 0) check("lat_89", lat, 21);
`else
         if (i == 0) check("lat_89", lat, 12);
`endif
      end

`ifdef FOP_SPLIT_EN
      begin
         int sx [5];
         bit sf [5];
         bit sp [5];
         sx = '{233, 13, 21, 7, 9};
         sf = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         sp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
         for (int i = 0; i < 5; i++) begin
            send(1, sx[i]);
            wait_result(1, gf, gb, gp, lat);
            check($sformatf("split_fib_%0d", sx[i]), gb, sf[i]);
            check($sformatf("split_prime_%0d", sx[i]), gp, sp[i]);
         end
      end
`endif

      // backpressure: hold the result for 10 cycles
      rmode[1] = 2;
      @(posedge clk);
      send(1, 97);
      wait_result(1, gf, gb, gp, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", ov[1], 1'b1);
         check("bp_fop", fop[1], 1'b1);
         check("bp_in_ready", ir[1], 1'b0);
      end
      rmode[1] = 0;
      @(negedge clk);
      check("bp_valid_at_ready", ov[1], 1'b1);
      @(negedge clk);
      check("bp_retired", ov[1], 1'b0);
      check("bp_idle_ready", ir[1], 1'b1);

      // reset in the middle of PRIME on 251
      send(1, 251);
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin pend[k] = 0; seen[k] = 0; hold[k] = 0; end
      #1;
      check("rst_mid_valid", ov[1], 1'b0);
      check("rst_mid_fop", fop[1], 1'b0);
      check("rst_mid_in_ready", ir[1], 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst_in_ready", ir[1], 1'b1);
      send(1, 4);
      wait_result(1, gf, gb, gp, lat);
      check("post_rst_4", gf, 1'b0);
      check("lat_4", lat, 7);

      // W=16 boundaries, then randomized operands with random consumer stalls
      send(2, 65521);
      wait_result(2, gf, gb, gp, lat);
      check("w16_65521", gf, 1'b1);
      check("lat_65521", lat, 281);
      send(2, 65535);
      wait_result(2, gf, gb, gp, lat);
      check("w16_65535", gf, 1'b0);
      send(2, 0);
      wait_result(2, gf, gb, gp, lat);
      check("w16_0", gf, 1'b1);

      rmode[2] = 1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) < 15) send(2, int'($urandom_range(0, 65535)));
         else                            send(2, int'($urandom_range(0, 1023)));
      end

      n = 0;
      while ((pend[0] || pend[1] || pend[2]) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) check("drain", pend[2], 1'b0);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
